// File: rtl/uart_pkg.sv
// Shared types and constants for the UART core: FSM state encodings,
// parity modes and the oversampling ratio.
package uart_pkg;

  localparam int unsigned OVERSAMPLE = 16;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_baud_gen.sv
// Free-running oversampling tick: one-clk pulse every CLK_FREQ/(BAUD*16) clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 100_000_000,
  parameter int unsigned BAUD     = 9600
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned DIV = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/uart_core.sv
// UART transmitter and receiver sharing one 16x baud tick; configurable
// payload width, parity mode and stop-bit count.
module uart_core
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD      = 9600,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_start,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_busy,
  output logic                 tx,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_busy,
  output logic                 rx_done,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam logic [3:0] LAST_TICK    = 4'(OVERSAMPLE - 1);
  localparam logic [3:0] START_SAMPLE = 4'(OVERSAMPLE / 2 - 1);
  localparam logic       ODD          = (PARITY == PAR_ODD);

  logic tick;

  uart_baud_gen #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD     (BAUD)
  ) u_baud (
    .clk   (clk),
    .rst_n (rst),
    .tick  (tick)
  );

  // ---------------- transmitter ----------------
  tx_state_t            tx_state, tx_next;
  logic [3:0]           tx_tick_cnt;
  logic [2:0]           tx_bit_cnt;
  logic [DATA_BITS-1:0] tx_shreg;
  logic                 tx_par;
  logic                 tx_bit_end;

  always_comb begin
    tx_bit_end = tick && (tx_tick_cnt == LAST_TICK);
    tx_next    = tx_state;
    unique case (tx_state)
      TX_IDLE:   if (tx_start) tx_next = TX_START;
      TX_START:  if (tx_bit_end) tx_next = TX_DATA;
      TX_DATA:
        if (tx_bit_end && tx_bit_cnt == 3'(DATA_BITS - 1))
          tx_next = (PARITY == PAR_NONE) ? TX_STOP : TX_PARITY;
      TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
      TX_STOP:
        if (tx_bit_end && tx_bit_cnt == 3'(STOP_BITS - 1)) tx_next = TX_IDLE;
      default:   tx_next = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state    <= TX_IDLE;
      tx_tick_cnt <= '0;
      tx_bit_cnt  <= '0;
      tx_shreg    <= '0;
      tx_par      <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE) begin
        tx_tick_cnt <= '0;
        tx_bit_cnt  <= '0;
        if (tx_start) begin
          tx_shreg <= tx_data;
          tx_par   <= (^tx_data) ^ ODD;
        end
      end else begin
        if (tick) tx_tick_cnt <= tx_tick_cnt + 4'd1;
        if (tx_bit_end) begin
          // bit counter restarts whenever the FSM changes phase
          tx_bit_cnt <= (tx_next != tx_state) ? 3'd0 : tx_bit_cnt + 3'd1;
          if (tx_state == TX_DATA) tx_shreg <= tx_shreg >> 1;
        end
      end
    end
  end

  always_comb begin
    tx = 1'b1;
    unique case (tx_state)
      TX_START:  tx = 1'b0;
      TX_DATA:   tx = tx_shreg[0];
      TX_PARITY: tx = tx_par;
      default:   tx = 1'b1;
    endcase
  end

  assign tx_busy = (tx_state != TX_IDLE);

  // ---------------- receiver ----------------
  rx_state_t            rx_state, rx_next;
  logic                 rx_meta, rx_sync;
  logic [3:0]           rx_tick_cnt;
  logic [2:0]           rx_bit_cnt;
  logic [DATA_BITS-1:0] rx_shreg;
  logic                 rx_par;
  logic                 rx_sample;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
    end
  end

  always_comb begin
    rx_sample = 1'b0;
    if (tick)
      rx_sample = (rx_state == RX_START) ? (rx_tick_cnt == START_SAMPLE)
                                         : (rx_tick_cnt == LAST_TICK);
    rx_next = rx_state;
    unique case (rx_state)
      RX_IDLE:   if (tick && !rx_sync) rx_next = RX_START;
      RX_START:  if (rx_sample) rx_next = rx_sync ? RX_IDLE : RX_DATA;
      RX_DATA:
        if (rx_sample && rx_bit_cnt == 3'(DATA_BITS - 1))
          rx_next = (PARITY == PAR_NONE) ? RX_STOP : RX_PARITY;
      RX_PARITY: if (rx_sample) rx_next = RX_STOP;
      RX_STOP:   if (rx_sample) rx_next = RX_IDLE;
      default:   rx_next = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state      <= RX_IDLE;
      rx_tick_cnt   <= '0;
      rx_bit_cnt    <= '0;
      rx_shreg      <= '0;
      rx_par        <= 1'b0;
      rx_data       <= '0;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
    end else begin
      rx_state      <= rx_next;
      rx_done       <= 1'b0;
      rx_parity_err <= 1'b0;
      rx_frame_err  <= 1'b0;
      // the start-bit half-period realigns subsequent samples to bit centres
      if (rx_state == RX_IDLE || (rx_state == RX_START && rx_sample))
        rx_tick_cnt <= '0;
      else if (tick)
        rx_tick_cnt <= rx_tick_cnt + 4'd1;
      if (rx_state == RX_IDLE) rx_bit_cnt <= '0;
      if (rx_sample) begin
        unique case (rx_state)
          RX_DATA: begin
            rx_shreg   <= {rx_sync, rx_shreg[DATA_BITS-1:1]};
            rx_bit_cnt <= rx_bit_cnt + 3'd1;
          end
          RX_PARITY: rx_par <= rx_sync;
          RX_STOP: begin
            rx_data       <= rx_shreg;
            rx_done       <= 1'b1;
            rx_frame_err  <= !rx_sync;
            rx_parity_err <= (PARITY != PAR_NONE) && ((^rx_shreg) ^ rx_par ^ ODD);
          end
          default: ;
        endcase
      end
    end
  end

  assign rx_busy = (rx_state != RX_IDLE);

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: three instances (8N1, 7E2 loopback, 8O1)
// at a 4-clock tick divider, so one line bit is 64 clocks.
module tb_uart_core;

  localparam int unsigned CLK_FREQ = 614_400;
  localparam int unsigned BAUD     = 9600;
  localparam int          BIT_CLKS = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // dut_a: 8N1, rx driven by bench
  logic       tx_start_a, tx_busy_a, tx_a, rx_a, rx_busy_a, rx_done_a, pe_a, fe_a;
  logic [7:0] tx_data_a, rx_data_a;
  // dut_b: 7E2, tx looped back to rx
  logic       tx_start_b, tx_busy_b, tx_b, rx_busy_b, rx_done_b, pe_b, fe_b;
  logic [6:0] tx_data_b, rx_data_b;
  // dut_c: 8O1, rx driven by bench
  logic       tx_start_c, tx_busy_c, tx_c, rx_c, rx_busy_c, rx_done_c, pe_c, fe_c;
  logic [7:0] tx_data_c, rx_data_c;

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_start(tx_start_a), .tx_data(tx_data_a), .tx_busy(tx_busy_a),
    .tx(tx_a), .rx(rx_a), .rx_data(rx_data_a), .rx_busy(rx_busy_a), .rx_done(rx_done_a),
    .rx_parity_err(pe_a), .rx_frame_err(fe_a));

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(tx_start_b), .tx_data(tx_data_b), .tx_busy(tx_busy_b),
    .tx(tx_b), .rx(tx_b), .rx_data(rx_data_b), .rx_busy(rx_busy_b), .rx_done(rx_done_b),
    .rx_parity_err(pe_b), .rx_frame_err(fe_b));

  uart_core #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_c (
    .clk(clk), .rst(rst), .tx_start(tx_start_c), .tx_data(tx_data_c), .tx_busy(tx_busy_c),
    .tx(tx_c), .rx(rx_c), .rx_data(rx_data_c), .rx_busy(rx_busy_c), .rx_done(rx_done_c),
    .rx_parity_err(pe_c), .rx_frame_err(fe_c));

  int vec_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    vec_cnt++;
    if (act < lo || act > hi) begin
      err_cnt++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  // rx_done capture and error-flag leakage monitor
  int         done_a = 0, done_b = 0, done_c = 0, busy_hits_a = 0;
  logic [7:0] cap_data_a, cap_data_b, cap_data_c;
  logic       cap_pe_a, cap_fe_a, cap_pe_b, cap_fe_b, cap_pe_c, cap_fe_c;
  logic       leak = 1'b0;

  always @(negedge clk) begin
    if (rx_done_a) begin
      done_a++; cap_data_a = rx_data_a; cap_pe_a = pe_a; cap_fe_a = fe_a;
    end else if (pe_a || fe_a) leak = 1'b1;
    if (rx_done_b) begin
      done_b++; cap_data_b = {1'b0, rx_data_b}; cap_pe_b = pe_b; cap_fe_b = fe_b;
    end else if (pe_b || fe_b) leak = 1'b1;
    if (rx_done_c) begin
      done_c++; cap_data_c = rx_data_c; cap_pe_c = pe_c; cap_fe_c = fe_c;
    end else if (pe_c || fe_c) leak = 1'b1;
    if (rx_busy_a) busy_hits_a++;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       sel;       // 0: dut_a (no parity), 1: dut_c (odd parity)
    logic [7:0] data;
    logic       par_good;
    logic       stop_v;
    logic [7:0] exp_data;
    logic       exp_pe;
    logic       exp_fe;
  } rx_vec_t;

  task automatic set_line(input logic sel, input logic v);
    if (sel) rx_c = v; else rx_a = v;
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic par_good,
                            input logic stop_v, input int stop_clks);
    logic p;
    set_line(sel, 1'b0);
    repeat (BIT_CLKS) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      set_line(sel, d[i]);
      repeat (BIT_CLKS) @(negedge clk);
    end
    if (sel) begin
      p = (~^d) ^ ~par_good;
      set_line(sel, p);
      repeat (BIT_CLKS) @(negedge clk);
    end
    set_line(sel, stop_v);
    repeat (stop_clks) @(negedge clk);
    set_line(sel, 1'b1);
  endtask

  rx_vec_t    vecs [8];
  logic [9:0] a5_bits;
  int         busy_len, mark, d0, h0;
  logic       fell;

  initial begin
    vecs[0] = '{1'b0, 8'h3C, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0};
    vecs[1] = '{1'b0, 8'h3C, 1'b1, 1'b0, 8'h3C, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[3] = '{1'b0, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 8'h0F, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 8'h80, 1'b0, 1'b0, 8'h80, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 8'h81, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    a5_bits = 10'b11_0100_1010;  // start, A5 LSB first, stop (index = bit slot)

    rst = 1'b0;
    tx_start_a = 1'b0; tx_data_a = '0; rx_a = 1'b1;
    tx_start_b = 1'b0; tx_data_b = '0;
    tx_start_c = 1'b0; tx_data_c = '0; rx_c = 1'b1;
    repeat (5) @(negedge clk);
    check("rst_tx", tx_a, 1);
    check("rst_tx_busy", tx_busy_a, 0);
    check("rst_rx_data", rx_data_a, 0);
    check("rst_rx_busy", rx_busy_a, 0);
    check("rst_rx_done", rx_done_a, 0);
    check("rst_pe", pe_c, 0);
    check("rst_fe", fe_c, 0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // A5 on 8N1 with an ignored mid-frame request and a restart right after busy falls
    tx_data_a = 8'hA5; tx_start_a = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0;
    check("tx_busy_rise", tx_busy_a, 1);
    fell = 1'b0; busy_len = 0; mark = 0;
    for (int n = 1; n <= 760; n++) begin
      if (n % BIT_CLKS == 32 && n / BIT_CLKS < 10)
        check($sformatf("tx_a5_bit%0d", n / BIT_CLKS), tx_a, a5_bits[n / BIT_CLKS]);
      if (n == 230) begin tx_data_a = 8'hFF; tx_start_a = 1'b1; end
      if (n == 231) tx_start_a = 1'b0;
      if (!fell) begin
        if (tx_busy_a) busy_len++;
        else begin
          fell = 1'b1; mark = n; tx_data_a = 8'h00; tx_start_a = 1'b1;
        end
      end else if (n == mark + 1) begin
        tx_start_a = 1'b0;
        check("tx_restart_busy", tx_busy_a, 1);
      end
      @(negedge clk);
    end
    check("tx_busy_fell", fell, 1);
    check_range("tx_busy_len_8n1", busy_len, 637, 640);
    for (int n = 0; n < 1000 && tx_busy_a; n++) @(negedge clk);
    check("tx_second_done", tx_busy_a, 0);

    // receiver frame table
    foreach (vecs[i]) begin
      d0 = vecs[i].sel ? done_c : done_a;
      send_frame(vecs[i].sel, vecs[i].data, vecs[i].par_good, vecs[i].stop_v, BIT_CLKS);
      repeat (2 * BIT_CLKS) @(negedge clk);
      if (vecs[i].sel) begin
        check($sformatf("v%0d_done", i), done_c - d0, 1);
        check($sformatf("v%0d_data", i), cap_data_c, vecs[i].exp_data);
        check($sformatf("v%0d_pe", i), cap_pe_c, vecs[i].exp_pe);
        check($sformatf("v%0d_fe", i), cap_fe_c, vecs[i].exp_fe);
      end else begin
        check($sformatf("v%0d_done", i), done_a - d0, 1);
        check($sformatf("v%0d_data", i), cap_data_a, vecs[i].exp_data);
        check($sformatf("v%0d_pe", i), cap_pe_a, vecs[i].exp_pe);
        check($sformatf("v%0d_fe", i), cap_fe_a, vecs[i].exp_fe);
      end
    end
    check("rx_data_hold", rx_data_a, 8'hFF);

    // back-to-back frames: next start follows the stop-bit sample closely
    d0 = done_a;
    send_frame(1'b0, 8'h12, 1'b1, 1'b1, 44);
    send_frame(1'b0, 8'h34, 1'b1, 1'b1, BIT_CLKS);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("b2b_done", done_a - d0, 2);
    check("b2b_data", cap_data_a, 8'h34);

    // 4-tick low glitch
    d0 = done_a; h0 = busy_hits_a;
    rx_a = 1'b0;
    repeat (16) @(negedge clk);
    rx_a = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("glitch_seen_busy", busy_hits_a > h0, 1);
    check("glitch_no_done", done_a - d0, 0);
    check("glitch_busy_idle", rx_busy_a, 0);

    // 7E2 loopback of 7'h55
    d0 = done_b;
    tx_data_b = 7'h55; tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_b = 1'b0;
    busy_len = 0;
    for (int n = 0; n < 1000 && tx_busy_b; n++) begin
      busy_len++;
      @(negedge clk);
    end
    check_range("tx_busy_len_7e2", busy_len, 701, 704);
    repeat (BIT_CLKS) @(negedge clk);
    check("lb_done", done_b - d0, 1);
    check("lb_data", cap_data_b, 8'h55);
    check("lb_pe", cap_pe_b, 0);
    check("lb_fe", cap_fe_b, 0);

    // reset in the middle of a frame
    tx_data_a = 8'h81; tx_start_a = 1'b1;
    tx_data_b = 7'h2A; tx_start_b = 1'b1;
    @(negedge clk);
    tx_start_a = 1'b0; tx_start_b = 1'b0;
    repeat (200) @(negedge clk);
    check("pre_rst_rx_busy", rx_busy_b, 1);
    check("pre_rst_tx_busy", tx_busy_a, 1);
    rst = 1'b0;
    #1;
    check("mid_rst_tx_a", tx_a, 1);
    check("mid_rst_tx_busy_a", tx_busy_a, 0);
    check("mid_rst_tx_b", tx_b, 1);
    check("mid_rst_tx_busy_b", tx_busy_b, 0);
    check("mid_rst_rx_busy_b", rx_busy_b, 0);
    check("mid_rst_rx_data_b", rx_data_b, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    check("post_rst_tx_busy", tx_busy_a, 0);
    check("post_rst_tx", tx_a, 1);

    check("err_flags_only_with_done", leak, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
